pt_dec: RTL

PT2262-style tri-state code decoder, the receive end of the `pt_enc` line code. It oversamples the serial line and measures high and low pulse widths. Each pulse pair is classified short/long, pairs are assembled into 12 tri-state code bits, and a frame is framed by the sync pulse. The decoded 24-bit address/data word is presented in the same 2-bit-per-codebit packing that `pt_enc` accepts on `ad`, so a looped-back frame reproduces its input word.

---
 rtl/pt_pkg.sv | 27 ++
 rtl/pt_pulse_meas.sv | 68 ++++++
 rtl/pt_dec.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the PT2262-style tri-state line code (pt_enc / pt_dec).
package pt_pkg;

    localparam logic [1:0] CB_ZERO  = 2'b00;
    localparam logic [1:0] CB_ONE   = 2'b01;
    localparam logic [1:0] CB_FLOAT = 2'b10;

    localparam int unsigned CHIPS_SHORT    = 4;
    localparam int unsigned CHIPS_LONG     = 12;
    localparam int unsigned CHIPS_SYNC_LOW = 124;
    localparam int unsigned CHIPS_FRAME    = 512;

    typedef enum logic [1:0] {S_HUNT, S_ARMED, S_RX, S_TAIL} pt_state_e;

    typedef enum logic [1:0] {CLS_BAD, CLS_SHORT, CLS_LONG} pt_cls_e;

    // Pulse width (clk cycles) to class; c is clk cycles per chip. Gaps are flagged separately.
    function automatic pt_cls_e classify(input int unsigned w, input int unsigned c);
        if (w >= 2 * c && w < 8 * c)
            return CLS_SHORT;
        else if (w >= 8 * c && w < 16 * c)
            return CLS_LONG;
        else
            return CLS_BAD;
    endfunction

endpackage

// File: rtl/pt_pulse_meas.sv
// Line synchroniser, edge detector and saturating pulse-width counter for pt_dec.
module pt_pulse_meas #(
    parameter int unsigned CHIP_DIV = 4,
    parameter int unsigned SYNC_MIN = 64,
    parameter int unsigned CW       = $clog2(SYNC_MIN * CHIP_DIV) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    output logic          rise,
    output logic          fall,
    output logic          gap,
    output logic [CW-1:0] width,
    output logic          level
);

    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_MIN * CHIP_DIV);

    logic          s1_q, s2_q, lvl_q;
    logic          rise_q, fall_q, gap_q, level_q;
    logic [CW-1:0] cnt_q, cnt_d, width_q;
    logic          edge_s;

    assign edge_s = s2_q ^ lvl_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_s)
            cnt_d = CW'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
    end

    // NOTE: every register here updates with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            gap_q   <= 1'b0;
            width_q <= '0;
            level_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            lvl_q  <= s2_q;
            cnt_q  <= cnt_d;
            rise_q <= edge_s & s2_q;
            fall_q <= edge_s & ~s2_q;
            // One-shot when a low first reaches the saturation value.
            gap_q  <= ~edge_s & ~lvl_q & (cnt_q == CNT_MAX - CW'(1));
            if (edge_s) begin
                width_q <= cnt_q;
                level_q <= lvl_q;
            end
        end
    end

    assign rise  = rise_q;
    assign fall  = fall_q;
    assign gap   = gap_q;
    assign width = width_q;
    assign level = level_q;

endmodule

// File: rtl/pt_dec.sv
// PT2262-style tri-state frame decoder: pulse-pair FSM and codebit shift register.
// Optional PT_DEC_MATCH_EN: only strobe when two consecutive frames decode identically.
module pt_dec
    import pt_pkg::*;
#(
    parameter int unsigned CHIP_DIV = 4,
    parameter int unsigned SYNC_MIN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] ad,
    output logic        valid,
    output logic        err
);

    localparam int unsigned CW = $clog2(SYNC_MIN * CHIP_DIV) + 1;

    logic          rise, fall, gap, level;
    logic [CW-1:0] width;

    pt_pulse_meas #(.CHIP_DIV(CHIP_DIV), .SYNC_MIN(SYNC_MIN), .CW(CW)) u_meas (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .rise  (rise),
        .fall  (fall),
        .gap   (gap),
        .width (width),
        .level (level)
    );

    pt_state_e   state_q, state_d;
    pt_cls_e     hi_cls_q, hi_cls_d, cls_w;
    logic        first_l_q, first_l_d;
    logic [4:0]  pair_cnt_q, pair_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        tail_ok_q, tail_ok_d;
    logic [23:0] ad_q, ad_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic        frame_ok, pair_ok, pair_l;
    logic [1:0]  cb;
`ifdef PT_DEC_MATCH_EN
    logic [23:0] cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
`endif

    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hi_cls_d   = hi_cls_q;
        first_l_d  = first_l_q;
        pair_cnt_d = pair_cnt_q;
        shift_d    = shift_q;
        tail_ok_d  = tail_ok_q;
        ad_d       = ad_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        frame_ok   = 1'b0;
        pair_ok    = 1'b0;
        pair_l     = 1'b0;
        cb         = CB_ZERO;
        cls_w      = classify(32'(width), CHIP_DIV);

        case (state_q)
            S_HUNT: if (gap) state_d = S_ARMED;
            S_ARMED: begin
                if (rise) begin
                    state_d    = S_RX;
                    pair_cnt_d = '0;
                end
            end
            S_RX: begin
                if (gap) begin
                    err_d   = 1'b1;
                    state_d = S_ARMED;
                end else if (fall && level) begin
                    if (cls_w == CLS_BAD) begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        hi_cls_d = cls_w;
                    end
                end else if (rise && !level) begin
                    pair_ok = (hi_cls_q == CLS_SHORT && cls_w == CLS_LONG) ||
                              (hi_cls_q == CLS_LONG  && cls_w == CLS_SHORT);
                    pair_l  = (hi_cls_q == CLS_LONG);
                    if (!pair_ok || (pair_cnt_q[0] && first_l_q && !pair_l)) begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        if (!pair_cnt_q[0]) begin
                            first_l_d = pair_l;
                        end else begin
                            cb      = first_l_q ? CB_ONE : (pair_l ? CB_FLOAT : CB_ZERO);
                            shift_d = {shift_q[21:0], cb};
                        end
                        if (pair_cnt_q == 5'd23) begin
                            state_d   = S_TAIL;
                            tail_ok_d = 1'b0;
                        end else begin
                            pair_cnt_d = pair_cnt_q + 5'd1;
                        end
                    end
                end
            end
            S_TAIL: begin
                // Sync gap is shared with the next frame, so both outcomes re-arm.
                if (gap) begin
                    state_d = S_ARMED;
                    if (tail_ok_q) frame_ok = 1'b1;
                    else           err_d    = 1'b1;
                end else if (fall && level) begin
                    if (cls_w == CLS_SHORT) begin
                        tail_ok_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end
                end else if (rise) begin
                    err_d   = 1'b1;
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase

`ifdef PT_DEC_MATCH_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        if (frame_ok) begin
            if (cand_vld_q && cand_q == shift_q) begin
                valid_d = 1'b1;
                ad_d    = shift_q;
            end else begin
                cand_d     = shift_q;
                cand_vld_d = 1'b1;
            end
        end
        if (err_d) cand_vld_d = 1'b0;
`else
        if (frame_ok) begin
            valid_d = 1'b1;
            ad_d    = shift_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HUNT;
            hi_cls_q   <= CLS_BAD;
            first_l_q  <= 1'b0;
            pair_cnt_q <= '0;
            shift_q    <= '0;
            tail_ok_q  <= 1'b0;
            ad_q       <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef PT_DEC_MATCH_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hi_cls_q   <= hi_cls_d;
            first_l_q  <= first_l_d;
            pair_cnt_q <= pair_cnt_d;
            shift_q    <= shift_d;
            tail_ok_q  <= tail_ok_d;
            ad_q       <= ad_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef PT_DEC_MATCH_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign ad    = ad_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
